// File: rtl/scarv_soc_dbg_master_if.sv
// Byte-stream command/response links plus memory-initiator bus of the debug master.
// Latency: none, wires only.
// Backpressure: rx/tx use valid/ready, memory bus uses req/gnt then recv/ack.
interface scarv_soc_dbg_master_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_wen;
   logic [3:0]  mem_strb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_recv;
   logic        mem_error;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   // Debug master side.
   modport master (
      input  rx_valid, rx_data, tx_ready, mem_gnt, mem_recv, mem_error, mem_rdata,
      output rx_ready, tx_valid, tx_data, mem_req, mem_wen, mem_strb, mem_addr,
      output mem_wdata, mem_ack
   );

   // Host link / memory side.
   modport slave (
      output rx_valid, rx_data, tx_ready, mem_gnt, mem_recv, mem_error, mem_rdata,
      input  rx_ready, tx_valid, tx_data, mem_req, mem_wen, mem_strb, mem_addr,
      input  mem_wdata, mem_ack
   );
endinterface

// File: rtl/scarv_soc_dbg_master.sv
// Debug master: turns 'R'/'W' byte commands into single 32-bit memory transactions.
// Latency: mem_req the cycle after the last command byte; tx_valid the cycle after recv&ack.
// Backpressure: rx_ready only while collecting a command; tx bytes held until tx_ready.
module scarv_soc_dbg_master #(
   parameter int unsigned CMD_TIMEOUT = 1_000_000
) (
   input  logic                         f_clk,
   input  logic                         g_resetn,
   scarv_soc_dbg_master_if.master       dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      WDATA   = 3'd2,
      REQ     = 3'd3,
      RSP     = 3'd4,
      TX_STAT = 3'd5,
      TX_DATA = 3'd6
   } state_t;

   localparam logic [7:0]  CMD_RD   = 8'h52;
   localparam logic [7:0]  CMD_WR   = 8'h57;
   localparam logic [7:0]  ST_OK    = 8'h06;
   localparam logic [7:0]  ST_ERR   = 8'h15;
   localparam logic [7:0]  ST_BAD   = 8'h3F;
   localparam logic [23:0] TMO_LAST = 24'(CMD_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        rdy_en;
   logic [1:0]  byte_cnt;
   logic        is_write;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [7:0]  status_q;
   logic [23:0] tmo_cnt;

   logic        rx_open;
   logic        rx_fire;
   logic        collecting;
   logic        tmo_hit;
   logic        last_byte;
   logic [31:0] addr_shift;
   logic [31:0] wdata_shift;

   // rx is held off until the first edge after reset release
   assign rx_open     = (state == IDLE) || (state == ADDR) || (state == WDATA);
   assign rx_fire     = dbg.rx_valid && rdy_en && rx_open;
   assign collecting  = (state == ADDR) || (state == WDATA);
   assign tmo_hit     = collecting && !rx_fire && (tmo_cnt == TMO_LAST);
   assign last_byte   = rx_fire && (byte_cnt == 2'd3);
   // Fields arrive LSB first, so each new byte enters at the top and shifts down.
   assign addr_shift  = {dbg.rx_data, addr_q[31:8]};
   assign wdata_shift = {dbg.rx_data, wdata_q[31:8]};

   // State register
   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) state <= IDLE;
      else           state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rx_fire) begin
               if (dbg.rx_data == CMD_RD || dbg.rx_data == CMD_WR) state_nxt = ADDR;
               else                                                 state_nxt = TX_STAT;
            end
         end
         ADDR: begin
            if (last_byte) begin
               if (is_write)                    state_nxt = WDATA;
               else if (addr_shift[1:0] != 2'b0) state_nxt = TX_STAT;
               else                             state_nxt = REQ;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
            end
         end
         WDATA: begin
            if (last_byte) begin
               if (addr_q[1:0] != 2'b0) state_nxt = TX_STAT;
               else                     state_nxt = REQ;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
            end
         end
         REQ:     if (dbg.mem_gnt)  state_nxt = RSP;
         RSP:     if (dbg.mem_recv) state_nxt = TX_STAT;
         TX_STAT: begin
            if (dbg.tx_ready) begin
               if (!is_write && status_q == ST_OK) state_nxt = TX_DATA;
               else                                state_nxt = IDLE;
            end
         end
         TX_DATA: if (dbg.tx_ready && byte_cnt == 2'd3) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; address/data come straight from the capture registers
   always_comb begin
      dbg.rx_ready  = rdy_en && rx_open;
      dbg.tx_valid  = (state == TX_STAT) || (state == TX_DATA);
      dbg.tx_data   = 8'h00;
      dbg.mem_req   = (state == REQ);
      dbg.mem_wen   = (state == REQ) && is_write;
      dbg.mem_strb  = (state == REQ) ? 4'hF : 4'h0;
      dbg.mem_ack   = (state == RSP);
      dbg.mem_addr  = addr_q;
      dbg.mem_wdata = wdata_q;
      if (state == TX_STAT) begin
         dbg.tx_data = status_q;
      end else if (state == TX_DATA) begin
         case (byte_cnt)
            2'd0:    dbg.tx_data = rdata_q[7:0];
            2'd1:    dbg.tx_data = rdata_q[15:8];
            2'd2:    dbg.tx_data = rdata_q[23:16];
            default: dbg.tx_data = rdata_q[31:24];
         endcase
      end
   end

   // Command capture, response capture, byte counter and inactivity timer
   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         rdy_en   <= 1'b0;
         byte_cnt <= 2'd0;
         is_write <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         status_q <= 8'h00;
         tmo_cnt  <= 24'h0;
      end else begin
         rdy_en <= 1'b1;

         if (state == IDLE && rx_fire) begin
            byte_cnt <= 2'd0;
            is_write <= (dbg.rx_data == CMD_WR);
         end else if (collecting && rx_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
         end else if (state == RSP && dbg.mem_recv) begin
            byte_cnt <= 2'd0;
         end else if (state == TX_DATA && dbg.tx_ready) begin
            byte_cnt <= byte_cnt + 2'd1;
         end

         if (state == ADDR && rx_fire)  addr_q  <= addr_shift;
         if (state == WDATA && rx_fire) wdata_q <= wdata_shift;

         if (state == RSP && dbg.mem_recv && !is_write) rdata_q <= dbg.mem_rdata;

         // Status is latched on entry to TX_STAT; its value depends on where we came from.
         if (state_nxt == TX_STAT && state != TX_STAT) begin
            if (state == IDLE)                        status_q <= ST_BAD;
            else if (state == RSP && !dbg.mem_error)  status_q <= ST_OK;
            else                                      status_q <= ST_ERR;
         end

         if (!collecting || rx_fire) tmo_cnt <= 24'h0;
         else                        tmo_cnt <= tmo_cnt + 24'h1;
      end
   end

endmodule

// File: tb/tb_scarv_soc_dbg_master.sv
// Randomized bench for the debug master against a command-level response model.
// Latency: checks mem_req / tx_valid one cycle after their triggers.
// Backpressure: random tx_ready plus a forced 5-cycle stall inside the read-data bytes.
module tb_scarv_soc_dbg_master;
   localparam int TMO = 8;

   logic f_clk = 1'b0;
   logic g_resetn;

   always #5 f_clk = ~f_clk;

   scarv_soc_dbg_master_if dbg();

   scarv_soc_dbg_master #(.CMD_TIMEOUT(TMO)) dut (
      .f_clk    (f_clk),
      .g_resetn (g_resetn),
      .dbg      (dbg)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wen;
      logic [3:0]  strb;
   } bus_t;

   bus_t        obs_bus[$];
   logic [7:0]  obs_tx[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          cfg_gnt_dly = 0;
   int          cfg_rsp_dly = 0;
   logic [31:0] cfg_rdata = 32'h0;
   logic        cfg_err = 1'b0;
   int          stall_len = 0;
   int          stall_cnt = 0;
   logic        chk_tx_next = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory target: grant after cfg_gnt_dly req cycles, respond after cfg_rsp_dly ack cycles
   initial begin
      int gcnt;
      int rcnt;
      gcnt = 0;
      rcnt = 0;
      dbg.mem_gnt   = 1'b0;
      dbg.mem_recv  = 1'b0;
      dbg.mem_error = 1'b0;
      dbg.mem_rdata = 32'h0;
      forever begin
         @(negedge f_clk);
         dbg.mem_gnt  = 1'b0;
         dbg.mem_recv = 1'b0;
         if (!g_resetn) begin
            gcnt = 0;
            rcnt = 0;
            chk_tx_next = 1'b0;
         end else begin
            if (chk_tx_next) begin
               chk("tx_lat", dbg.tx_valid, 1'b1);
               chk_tx_next = 1'b0;
            end
            if (dbg.mem_req) begin
               if (gcnt >= cfg_gnt_dly) begin
                  dbg.mem_gnt = 1'b1;
                  gcnt = 0;
                  obs_bus.push_back('{dbg.mem_addr, dbg.mem_wdata, dbg.mem_wen, dbg.mem_strb});
               end else gcnt++;
            end else if (dbg.mem_ack) begin
               if (rcnt >= cfg_rsp_dly) begin
                  dbg.mem_recv  = 1'b1;
                  dbg.mem_rdata = cfg_rdata;
                  dbg.mem_error = cfg_err;
                  rcnt = 0;
                  chk_tx_next = 1'b1;
               end else begin
                  rcnt++;
                  dbg.mem_rdata = $urandom;
                  dbg.mem_error = 1'($urandom_range(0, 1));
               end
            end
         end
      end
   end

   // tx sink: random ready, records accepted bytes, checks bytes stay put while stalled
   initial begin
      logic       stalled;
      logic [7:0] held;
      stalled = 1'b0;
      held    = 8'h00;
      dbg.tx_ready = 1'b0;
      forever begin
         @(negedge f_clk);
         if (!g_resetn) begin
            stalled = 1'b0;
            dbg.tx_ready = 1'b0;
         end else begin
            if (stalled) begin
               chk("tx_hold_vld", dbg.tx_valid, 1'b1);
               chk("tx_hold_dat", dbg.tx_data, held);
               chk("rx_rdy_in_tx", dbg.rx_ready, 1'b0);
            end
            if (stall_cnt < stall_len && dbg.tx_valid && obs_tx.size() == 1) begin
               dbg.tx_ready = 1'b0;
               stall_cnt++;
            end else begin
               dbg.tx_ready = ($urandom_range(0, 3) != 0);
            end
            if (dbg.tx_valid && dbg.tx_ready) begin
               obs_tx.push_back(dbg.tx_data);
               stalled = 1'b0;
            end else if (dbg.tx_valid) begin
               stalled = 1'b1;
               held = dbg.tx_data;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   // Offer one byte after 'gap' idle cycles; returns just after the accepting edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      @(negedge f_clk);
      repeat (gap) @(negedge f_clk);
      dbg.rx_valid = 1'b1;
      dbg.rx_data  = b;
      while (!dbg.rx_ready && t < 2000) begin
         @(negedge f_clk);
         t++;
      end
      if (!dbg.rx_ready) chk("rx_accept", dbg.rx_ready, 1'b1);
      @(posedge f_clk);
      #1 dbg.rx_valid = 1'b0;
   endtask

   task automatic wait_done(input int n_exp);
      int to;
      to = 0;
      while ((obs_tx.size() < n_exp || !dbg.rx_ready) && to < 1000) begin
         @(negedge f_clk);
         to++;
      end
      chk("rsp_done", (to < 1000), 1'b1);
      repeat (3) @(negedge f_clk);
   endtask

   // Full command: model expectations, drive bytes, compare bus transaction and tx bytes
   task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input bit err, input int gd, input int rdl,
                          input int max_gap, input int long_idx);
      logic [7:0] cmd[$];
      logic [7:0] exp_tx[$];
      bit         aligned;
      int         g;
      cmd.push_back(wr ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) cmd.push_back(a[8*i +: 8]);
      if (wr) for (int i = 0; i < 4; i++) cmd.push_back(d[8*i +: 8]);
      aligned = (a[1:0] == 2'b00);
      if (!aligned || err) exp_tx.push_back(8'h15);
      else begin
         exp_tx.push_back(8'h06);
         if (!wr) for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
      end
      cfg_gnt_dly = gd;
      cfg_rsp_dly = rdl;
      cfg_rdata   = rd;
      cfg_err     = err;
      obs_bus.delete();
      obs_tx.delete();
      foreach (cmd[i]) begin
         g = (i == long_idx) ? TMO - 1 : int'($urandom_range(0, max_gap));
         send_byte(cmd[i], g);
      end
      @(negedge f_clk);
      chk("req_lat", dbg.mem_req, aligned);
      wait_done(exp_tx.size());
      chk("tx_count", obs_tx.size(), exp_tx.size());
      foreach (exp_tx[i]) if (i < obs_tx.size()) chk("tx_byte", obs_tx[i], exp_tx[i]);
      chk("bus_count", obs_bus.size(), aligned ? 1 : 0);
      if (aligned && obs_bus.size() > 0) begin
         chk("bus_addr", obs_bus[0].addr, a);
         chk("bus_wen", obs_bus[0].wen, wr);
         chk("bus_strb", obs_bus[0].strb, 4'hF);
         if (wr) chk("bus_wdata", obs_bus[0].wdata, d);
      end
   endtask

   task automatic run_junk(input logic [7:0] b);
      obs_bus.delete();
      obs_tx.delete();
      send_byte(b, 0);
      wait_done(1);
      chk("junk_count", obs_tx.size(), 1);
      if (obs_tx.size() > 0) chk("junk_byte", obs_tx[0], 8'h3F);
      chk("junk_bus", obs_bus.size(), 0);
   endtask

   initial begin
      int          viol;
      int          sel;
      int          to;
      bit          wr;
      bit          err;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      logic [7:0]  jb;

      g_resetn     = 1'b0;
      dbg.rx_valid = 1'b0;
      dbg.rx_data  = 8'h00;
      repeat (3) @(negedge f_clk);
      chk("rst_rx_ready", dbg.rx_ready, 1'b0);
      chk("rst_tx_valid", dbg.tx_valid, 1'b0);
      chk("rst_tx_data", dbg.tx_data, 8'h00);
      chk("rst_mem_req", dbg.mem_req, 1'b0);
      chk("rst_mem_ack", dbg.mem_ack, 1'b0);
      chk("rst_mem_wen", dbg.mem_wen, 1'b0);
      chk("rst_mem_strb", dbg.mem_strb, 4'h0);
      chk("rst_mem_addr", dbg.mem_addr, 32'h0);
      chk("rst_mem_wdata", dbg.mem_wdata, 32'h0);
      #2 g_resetn = 1'b1;
      #1 chk("rx_ready_pre_edge", dbg.rx_ready, 1'b0);
      @(posedge f_clk);
      #1 chk("rx_ready_post_edge", dbg.rx_ready, 1'b1);

      // Directed write and reads
      run_cmd(1'b1, 32'h00010000, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0, -1);
      run_cmd(1'b0, 32'h00010004, 32'h0, 32'h12345678, 1'b0, 1, 1, 0, -1);
      run_cmd(1'b0, 32'h00010004, 32'h0, 32'h12345678, 1'b1, 0, 2, 0, -1);

      // Long stall on a read-data byte
      stall_cnt = 0;
      stall_len = 5;
      run_cmd(1'b0, 32'h00000040, 32'h0, 32'hA5C33C5A, 1'b0, 0, 0, 0, -1);
      chk("stall_seen", stall_cnt, 5);
      stall_len = 0;

      // Misaligned read and a non-command byte
      run_cmd(1'b0, 32'h00000003, 32'h0, 32'h0, 1'b0, 0, 0, 0, -1);
      run_junk(8'hAA);

      // Partial command abandoned after TMO idle cycles
      obs_bus.delete();
      obs_tx.delete();
      send_byte(8'h57, 0);
      send_byte(8'h00, 0);
      viol = 0;
      repeat (TMO + 4) begin
         @(negedge f_clk);
         if (dbg.tx_valid || dbg.mem_req) viol++;
      end
      chk("tmo_quiet", viol, 0);
      chk("tmo_no_tx", obs_tx.size(), 0);
      chk("tmo_rx_ready", dbg.rx_ready, 1'b1);
      run_cmd(1'b0, 32'h00010008, 32'h0, 32'hCAFEF00D, 1'b0, 0, 0, 0, -1);

      // One idle gap of TMO-1 cycles mid-address must not time out
      run_cmd(1'b0, 32'h00002000, 32'h0, 32'h0BADC0DE, 1'b0, 0, 0, 0, 2);

      // Reset while waiting for the response
      cfg_rsp_dly = 50;
      cfg_gnt_dly = 0;
      obs_bus.delete();
      obs_tx.delete();
      send_byte(8'h52, 0);
      send_byte(8'h20, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      to = 0;
      while (!dbg.mem_ack && to < 100) begin
         @(negedge f_clk);
         to++;
      end
      chk("rsp_reached", dbg.mem_ack, 1'b1);
      #2 g_resetn = 1'b0;
      #1;
      chk("rst_rsp_ack", dbg.mem_ack, 1'b0);
      chk("rst_rsp_tx_valid", dbg.tx_valid, 1'b0);
      chk("rst_rsp_req", dbg.mem_req, 1'b0);
      chk("rst_rsp_addr", dbg.mem_addr, 32'h0);
      @(negedge f_clk);
      #2 g_resetn = 1'b1;
      cfg_rsp_dly = 0;
      obs_bus.delete();
      obs_tx.delete();
      viol = 0;
      repeat (10) begin
         @(negedge f_clk);
         if (dbg.tx_valid || dbg.mem_req || dbg.mem_ack) viol++;
      end
      chk("post_rst_quiet", viol, 0);
      chk("post_rst_no_tx", obs_tx.size(), 0);
      chk("post_rst_no_bus", obs_bus.size(), 0);
      run_cmd(1'b0, 32'h00000020, 32'h0, 32'h76543210, 1'b0, 0, 0, 0, -1);

      // Randomized commands
      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0) begin
            jb = 8'($urandom);
            if (jb == 8'h52 || jb == 8'h57) jb = 8'hAA;
            run_junk(jb);
         end else begin
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            d   = $urandom;
            rd  = $urandom;
            err = ($urandom_range(0, 3) == 0);
            run_cmd(wr, a, d, rd, err, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3, -1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500_000;
      n_mis++;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $fatal(1, "watchdog expired");
   end

endmodule
